// File: rtl/riscv_trace_collector.sv
// Retirement-side trace capture: buffers one record per retiring instruction,
// completes late (load) results from the WB port, and releases records in program order.
module riscv_trace_collector #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid_i,
    input  logic [31:0]             ex_pc_i,
    input  logic [31:0]             ex_instr_i,
    input  logic                    ex_rd_we_i,
    input  logic [5:0]              ex_rd_addr_i,
    input  logic [31:0]             ex_rd_wdata_i,
    input  logic                    ex_load_i,
    input  logic                    wb_we_i,
    input  logic [5:0]              wb_addr_i,
    input  logic [31:0]             wb_wdata_i,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output logic [31:0]             trace_pc_o,
    output logic [31:0]             trace_instr_o,
    output logic                    trace_rd_we_o,
    output logic [5:0]              trace_rd_addr_o,
    output logic [31:0]             trace_rd_wdata_o,
    output logic [$clog2(DEPTH):0]  occupancy_o,
    output logic                    overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    logic [31:0]     pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     wdata_q [DEPTH];
    logic [5:0]      addr_q  [DEPTH];
    logic [DEPTH-1:0] we_q;
    logic [DEPTH-1:0] pend_q;
    logic            ovf_q;

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;
    logic            push_pend;

    logic            wb_hit;
    logic [AW-1:0]   wb_idx;
    logic [AW-1:0]   slot;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign occupancy_o = wr_ptr - rd_ptr;
    assign overflow_o  = ovf_q;

    // Handshake: the head record is offered while trace_valid_o is high and is
    // consumed on any rising edge where trace_ready_i is also high. Once offered,
    // the head and its fields do not change until that accepting edge.
    assign trace_valid_o    = !empty && !pend_q[rd_idx];
    assign trace_pc_o       = pc_q[rd_idx];
    assign trace_instr_o    = instr_q[rd_idx];
    assign trace_rd_we_o    = we_q[rd_idx];
    assign trace_rd_addr_o  = addr_q[rd_idx];
    assign trace_rd_wdata_o = wdata_q[rd_idx];

    assign pop       = trace_valid_o && trace_ready_i;
    assign push      = ex_valid_i && (!full || pop);
    assign drop      = ex_valid_i && full && !pop;
    assign push_pend = ex_rd_we_i && ex_load_i;

    // Walk outward from the head so the oldest matching pending slot wins;
    // only slots occupied before this edge are candidates.
    always_comb begin
        wb_hit = 1'b0;
        wb_idx = '0;
        slot   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_idx + AW'(i);
            if (!wb_hit && wb_we_i && (PW'(i) < occupancy_o) &&
                pend_q[slot] && (addr_q[slot] == wb_addr_i)) begin
                wb_hit = 1'b1;
                wb_idx = slot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            we_q   <= '0;
            pend_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                wdata_q[i] <= '0;
                addr_q[i]  <= '0;
            end
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wb_hit) begin
                wdata_q[wb_idx] <= wb_wdata_i;
                pend_q[wb_idx]  <= 1'b0;
            end
            // A pushed slot is never the WB target in the same cycle: with the
            // buffer full, the slot being reused is the head being popped.
            if (push) begin
                wr_ptr          <= wr_ptr + PW'(1);
                pc_q[wr_idx]    <= ex_pc_i;
                instr_q[wr_idx] <= ex_instr_i;
                we_q[wr_idx]    <= ex_rd_we_i;
                addr_q[wr_idx]  <= ex_rd_addr_i;
                pend_q[wr_idx]  <= push_pend;
                wdata_q[wr_idx] <= push_pend ? 32'h0 : ex_rd_wdata_i;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_trace_collector.sv
// Directed and backpressure bench for riscv_trace_collector: drives retirements and late
// writebacks, predicts the in-order record stream in a queue and compares the tracer port.
module tb_riscv_trace_collector;

    localparam int DEPTH = 4;
    localparam int REC_W = 103;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_instr_i;
    logic        ex_rd_we_i;
    logic [5:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_wdata_i;
    logic        ex_load_i;
    logic        wb_we_i;
    logic [5:0]  wb_addr_i;
    logic [31:0] wb_wdata_i;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_pc_o;
    logic [31:0] trace_instr_o;
    logic        trace_rd_we_o;
    logic [5:0]  trace_rd_addr_o;
    logic [31:0] trace_rd_wdata_o;
    logic [$clog2(DEPTH):0] occupancy_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    // Record layout: {pc, instr, rd_we, rd_addr, rd_wdata}
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] mon_rec;
    logic             prev_stall;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_data;
    logic [5:0]  r_addr;
    logic        r_we;
    logic        r_ld;
    logic        wb_due;
    logic [5:0]  wb_a;
    logic [31:0] wb_d;
    int          n_push;

    riscv_trace_collector #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid_i       (ex_valid_i),
        .ex_pc_i          (ex_pc_i),
        .ex_instr_i       (ex_instr_i),
        .ex_rd_we_i       (ex_rd_we_i),
        .ex_rd_addr_i     (ex_rd_addr_i),
        .ex_rd_wdata_i    (ex_rd_wdata_i),
        .ex_load_i        (ex_load_i),
        .wb_we_i          (wb_we_i),
        .wb_addr_i        (wb_addr_i),
        .wb_wdata_i       (wb_wdata_i),
        .trace_valid_o    (trace_valid_o),
        .trace_ready_i    (trace_ready_i),
        .trace_pc_o       (trace_pc_o),
        .trace_instr_o    (trace_instr_o),
        .trace_rd_we_o    (trace_rd_we_o),
        .trace_rd_addr_o  (trace_rd_addr_o),
        .trace_rd_wdata_o (trace_rd_wdata_o),
        .occupancy_o      (occupancy_o),
        .overflow_o       (overflow_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        wb_we_i    = 1'b0;
    endtask

    // For loads, wdata is the value the bench will later write back; the EX
    // data bus carries its complement so a DUT that latches it is caught.
    task automatic push_rec(input logic [31:0] pc, input logic [31:0] instr,
                            input logic we, input logic [5:0] addr,
                            input logic [31:0] wdata, input logic ld, input logic keep);
        ex_valid_i    = 1'b1;
        ex_pc_i       = pc;
        ex_instr_i    = instr;
        ex_rd_we_i    = we;
        ex_rd_addr_i  = addr;
        ex_load_i     = ld;
        ex_rd_wdata_i = (ld && we) ? ~wdata : wdata;
        if (keep) exp_q.push_back({pc, instr, we, addr, wdata});
    endtask

    task automatic set_wb(input logic [5:0] addr, input logic [31:0] data);
        wb_we_i    = 1'b1;
        wb_addr_i  = addr;
        wb_wdata_i = data;
    endtask

    task automatic drain(input int limit);
        trace_ready_i = 1'b1;
        for (int k = 0; k < limit && exp_q.size() != 0; k++) step();
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_occ", 32'(occupancy_o), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_valid", 32'(trace_valid_o), 32'd1);
            if (trace_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rec", 32'(trace_valid_o), 32'd0);
                end else begin
                    mon_rec = exp_q[0];
                    check("rec_pc", trace_pc_o, mon_rec[102:71]);
                    check("rec_instr", trace_instr_o, mon_rec[70:39]);
                    check("rec_we_addr", {25'd0, trace_rd_we_o, trace_rd_addr_o},
                          {25'd0, mon_rec[38:32]});
                    check("rec_wdata", trace_rd_wdata_o, mon_rec[31:0]);
                    if (trace_ready_i) mon_rec = exp_q.pop_front();
                end
            end
            prev_stall = trace_valid_o && !trace_ready_i;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        ex_valid_i = 1'b0; ex_pc_i = '0; ex_instr_i = '0; ex_rd_we_i = 1'b0;
        ex_rd_addr_i = '0; ex_rd_wdata_i = '0; ex_load_i = 1'b0;
        wb_we_i = 1'b0; wb_addr_i = '0; wb_wdata_i = '0;
        trace_ready_i = 1'b0;
        prev_stall = 1'b0;
        wb_due = 1'b0; wb_a = '0; wb_d = '0;
        step();
        step();
        rst_n = 1'b1;

        check("rst_valid", 32'(trace_valid_o), 32'd0);
        check("rst_occ", 32'(occupancy_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_pc", trace_pc_o, 32'd0);
        check("rst_wdata", trace_rd_wdata_o, 32'd0);

        // In-order stream: one record out per cycle, first in the cycle after the push.
        trace_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_rec(32'h100 + 32'(i) * 4, 32'h0000_0093 + (32'(i) << 20), 1'b1,
                     6'(i + 1), 32'(i) * 32'h1111, 1'b0, 1'b1);
            step();
            check("stream_valid", 32'(trace_valid_o), 32'd1);
            check("stream_pc", trace_pc_o, 32'h100 + 32'(i) * 4);
        end
        step();
        check("stream_end_valid", 32'(trace_valid_o), 32'd0);
        check("stream_end_occ", 32'(occupancy_o), 32'd0);

        // Load at the head blocks the younger ALU record until WB.
        push_rec(32'h200, 32'h0002_A283, 1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 1'b1);
        step();
        check("ldblk_v1", 32'(trace_valid_o), 32'd0);
        push_rec(32'h204, 32'h0013_0313, 1'b1, 6'd6, 32'h0000_0066, 1'b0, 1'b1);
        step();
        check("ldblk_v2", 32'(trace_valid_o), 32'd0);
        check("ldblk_occ", 32'(occupancy_o), 32'd2);
        step();
        check("ldblk_v3", 32'(trace_valid_o), 32'd0);
        set_wb(6'd5, 32'hDEADBEEF);
        step();
        check("ldblk_v4", 32'(trace_valid_o), 32'd1);
        check("ldblk_pc0", trace_pc_o, 32'h200);
        check("ldblk_data0", trace_rd_wdata_o, 32'hDEADBEEF);
        step();
        check("ldblk_pc1", trace_pc_o, 32'h204);
        check("ldblk_data1", trace_rd_wdata_o, 32'h66);
        step();
        check("ldblk_end", 32'(trace_valid_o), 32'd0);

        // Two loads to x7: WB goes to the older pending slot first.
        push_rec(32'h300, 32'h0003_A383, 1'b1, 6'd7, 32'h1, 1'b1, 1'b1);
        step();
        push_rec(32'h304, 32'h0043_A383, 1'b1, 6'd7, 32'h2, 1'b1, 1'b1);
        step();
        set_wb(6'd7, 32'h1);
        step();
        check("dup_pc0", trace_pc_o, 32'h300);
        check("dup_data0", trace_rd_wdata_o, 32'h1);
        set_wb(6'd7, 32'h2);
        step();
        check("dup_valid1", 32'(trace_valid_o), 32'd1);
        check("dup_pc1", trace_pc_o, 32'h304);
        check("dup_data1", trace_rd_wdata_o, 32'h2);
        step();
        check("dup_end", 32'(trace_valid_o), 32'd0);

        // Overflow: fifth record into a full, stalled buffer is dropped.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_rec(32'h500 + 32'(i) * 4, 32'h0000_0013, 1'b1, 6'(10 + i),
                     32'hA000 + 32'(i), 1'b0, (i < 4) ? 1'b1 : 1'b0);
            step();
            if (i == 3) check("ovf_before", 32'(overflow_o), 32'd0);
        end
        check("ovf_occ", 32'(occupancy_o), 32'd4);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        trace_ready_i = 1'b1;
        push_rec(32'h514, 32'h0000_0013, 1'b1, 6'd15, 32'hA005, 1'b0, 1'b1);
        step();
        check("full_pushpop_occ", 32'(occupancy_o), 32'd4);
        check("full_pushpop_ovf", 32'(overflow_o), 32'd1);
        drain(20);

        // Reset mid-operation with a pending load in the buffer.
        trace_ready_i = 1'b0;
        push_rec(32'h400, 32'h0000_0013, 1'b1, 6'd8, 32'h88, 1'b0, 1'b1);
        step();
        push_rec(32'h404, 32'h0004_A483, 1'b1, 6'd9, 32'h1234, 1'b1, 1'b1);
        step();
        push_rec(32'h408, 32'h0000_0013, 1'b1, 6'd10, 32'hAA, 1'b0, 1'b1);
        step();
        check("mid_occ", 32'(occupancy_o), 32'd3);
        do_reset();
        check("mid_rst_valid", 32'(trace_valid_o), 32'd0);
        check("mid_rst_occ", 32'(occupancy_o), 32'd0);
        check("mid_rst_ovf", 32'(overflow_o), 32'd0);
        check("mid_rst_pc", trace_pc_o, 32'd0);
        set_wb(6'd9, 32'h1234);
        step();
        check("mid_wb_valid", 32'(trace_valid_o), 32'd0);
        check("mid_wb_occ", 32'(occupancy_o), 32'd0);
        check("mid_wb_data", trace_rd_wdata_o, 32'd0);

        // Backpressure: random ready, mixed ALU/load records, WB one cycle after each load.
        r_pc = 32'h1000;
        n_push = 0;
        for (int cyc = 0; cyc < 3000 && n_push < 200; cyc++) begin
            check("rand_occ", 32'(occupancy_o), 32'(exp_q.size()));
            trace_ready_i = ($urandom_range(0, 2) != 0);
            if (wb_due) begin
                set_wb(wb_a, wb_d);
                wb_due = 1'b0;
            end
            if (exp_q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
                r_ld    = ($urandom_range(0, 3) == 0);
                r_we    = r_ld ? 1'b1 : ($urandom_range(0, 4) != 0);
                r_addr  = 6'($urandom_range(0, 63));
                r_data  = $urandom;
                r_instr = $urandom;
                push_rec(r_pc, r_instr, r_we, r_addr, r_data, r_ld, 1'b1);
                if (r_ld) begin
                    wb_due = 1'b1;
                    wb_a   = r_addr;
                    wb_d   = r_data;
                end
                r_pc = r_pc + 4;
                n_push++;
            end
            step();
        end
        if (wb_due) begin
            set_wb(wb_a, wb_d);
            wb_due = 1'b0;
        end
        check("rand_pushes", 32'(n_push), 32'd200);
        drain(50);
        check("final_ovf", 32'(overflow_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
